aes_out_buffer: RTL and testbench

//   Result buffer directly downstream of encrypt_engine. Captures each 128-bit ciphertext beat (out/out_valid)

---
 rtl/aes_out_buffer.sv | 97 +++++++++
 tb/tb_aes_out_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/aes_out_buffer.sv
// Ciphertext result FIFO between encrypt_engine and the consumer.
// Hysteresis halt keeps in-flight engine beats from being dropped.
module aes_out_buffer #(
  parameter int DATA_W      = 128,
  parameter int DEPTH       = 8,
  parameter int HALT_MARGIN = 3,
  parameter int RESUME_FREE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          eng_out,
  input  logic                       eng_out_valid,
  output logic                       eng_halt,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                blk_count,
  output logic                       overflow_err,
  input  logic                       err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);
  localparam logic [OW-1:0] HALT_OCC = OW'(DEPTH - HALT_MARGIN);
  localparam logic [OW-1:0] RUN_OCC  = OW'(DEPTH - RESUME_FREE);

  typedef enum logic {RUN, HOLD} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              full, pop, push, drop;

  assign m_valid = (occupancy != '0);
  assign full    = (occupancy == FULL_OCC);
  assign pop     = m_valid & m_ready;
  assign push    = eng_out_valid & (~full | pop);
  assign drop    = eng_out_valid & full & ~pop;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign eng_halt = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst && !flush && push)
      mem[wr_ptr] <= eng_out;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      blk_count <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PW'(1);
        blk_count <= blk_count + 32'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      occupancy <= occupancy + OW'(push) - OW'(pop);
    end
  end

  // A beat lost in a flush cycle is intentional, not an overflow.
  always_ff @(posedge clk) begin
    if (rst)
      overflow_err <= 1'b0;
    else if (drop && !flush)
      overflow_err <= 1'b1;
    else if (err_clr)
      overflow_err <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN:  if (occupancy >= HALT_OCC) state_nxt = HOLD;
        HOLD: if (occupancy <= RUN_OCC)  state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_out_buffer.sv
// Directed bench for aes_out_buffer with a data-order scoreboard.
// Expected beats are queued when driven and checked when popped.
module tb_aes_out_buffer;

  logic         clk = 1'b0;
  logic         rst, flush, eng_out_valid, m_ready, err_clr;
  logic [127:0] eng_out;
  logic         eng_halt, m_valid, overflow_err;
  logic [127:0] m_data;
  logic [3:0]   occupancy;
  logic [31:0]  blk_count;

  int errors = 0;
  int checks = 0;
  logic [127:0] q[$];
  logic [127:0] sb_exp;

  localparam logic [127:0] BLK  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] DEAD = 128'hdead000000000000000000000000beef;

  aes_out_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .eng_out(eng_out), .eng_out_valid(eng_out_valid),
    .eng_halt(eng_halt),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .occupancy(occupancy), .blk_count(blk_count),
    .overflow_err(overflow_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every accepted pop against the queued order.
  always @(negedge clk) begin
    if (!rst && !flush && m_valid === 1'b1 && m_ready === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL sb_pop observed=%0h expected=<empty>", m_data);
      end else begin
        sb_exp = q.pop_front();
        assert (m_data === sb_exp) else begin
          errors++;
          $error("FAIL sb_data observed=%0h expected=%0h", m_data, sb_exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; eng_out_valid = 1'b0;
    m_ready = 1'b0; err_clr = 1'b0; eng_out = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset mid-traffic at occupancy 5
    for (int i = 0; i < 5; i++) begin
      eng_out = 128'(100 + i); eng_out_valid = 1'b1;
      q.push_back(eng_out);
      tick();
    end
    eng_out_valid = 1'b0;
    chk("pre_rst_occ", 128'(occupancy), 128'd5);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    q.delete();
    chk("rst_valid", 128'(m_valid), 128'd0);
    chk("rst_occ", 128'(occupancy), 128'd0);
    chk("rst_halt", 128'(eng_halt), 128'd0);
    chk("rst_blk", 128'(blk_count), 128'd0);
    chk("rst_ovf", 128'(overflow_err), 128'd0);
    chk("rst_data", m_data, 128'd0);

    // Single block, latency 1, no bypass
    eng_out = BLK; eng_out_valid = 1'b1; m_ready = 1'b1;
    q.push_back(BLK);
    chk("nobypass_valid", 128'(m_valid), 128'd0);
    tick();
    eng_out_valid = 1'b0;
    chk("single_valid", 128'(m_valid), 128'd1);
    chk("single_data", m_data, BLK);
    chk("single_blk", 128'(blk_count), 128'd1);
    tick();
    chk("single_occ", 128'(occupancy), 128'd0);

    // Hysteresis
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      eng_out = 128'(200 + i); eng_out_valid = 1'b1;
      q.push_back(eng_out);
      tick();
    end
    eng_out_valid = 1'b0;
    chk("hys_occ5", 128'(occupancy), 128'd5);
    chk("hys_halt_lat", 128'(eng_halt), 128'd0);
    tick();
    chk("hys_halt_on", 128'(eng_halt), 128'd1);
    m_ready = 1'b1;
    tick();
    chk("hys_occ4", 128'(occupancy), 128'd4);
    chk("hys_halt_hold", 128'(eng_halt), 128'd1);
    tick();
    chk("hys_halt_off", 128'(eng_halt), 128'd0);
    tick(); tick(); tick();
    chk("hys_drain", 128'(occupancy), 128'd0);
    chk("hys_blk", 128'(blk_count), 128'd6);

    // Full with simultaneous push and pop
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      eng_out = 128'(300 + i); eng_out_valid = 1'b1;
      q.push_back(eng_out);
      tick();
    end
    chk("full_occ", 128'(occupancy), 128'd8);
    chk("full_halt", 128'(eng_halt), 128'd1);
    m_ready = 1'b1; eng_out = 128'h1;
    q.push_back(128'h1);
    tick();
    eng_out_valid = 1'b0;
    chk("pp_occ", 128'(occupancy), 128'd8);
    chk("pp_ovf", 128'(overflow_err), 128'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("pp_drain", 128'(occupancy), 128'd0);
    chk("pp_sb_empty", 128'(q.size()), 128'd0);
    chk("pp_blk", 128'(blk_count), 128'd15);

    // Overflow
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      eng_out = 128'(400 + i); eng_out_valid = 1'b1;
      q.push_back(eng_out);
      tick();
    end
    eng_out = DEAD;
    tick();
    eng_out_valid = 1'b0;
    chk("ovf_set", 128'(overflow_err), 128'd1);
    chk("ovf_blk", 128'(blk_count), 128'd23);
    chk("ovf_occ", 128'(occupancy), 128'd8);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", 128'(overflow_err), 128'd0);

    // err_clr colliding with a drop: set wins
    eng_out = DEAD; eng_out_valid = 1'b1; err_clr = 1'b1;
    tick();
    eng_out_valid = 1'b0; err_clr = 1'b0;
    chk("ovf_set_wins", 128'(overflow_err), 128'd1);

    // Flush at occupancy 6 with overflow set and a beat arriving
    m_ready = 1'b1;
    tick(); tick();
    m_ready = 1'b0;
    chk("fl_pre_occ", 128'(occupancy), 128'd6);
    chk("fl_pre_halt", 128'(eng_halt), 128'd1);
    flush = 1'b1; eng_out = 128'h77; eng_out_valid = 1'b1;
    tick();
    flush = 1'b0; eng_out_valid = 1'b0;
    q.delete();
    chk("fl_occ", 128'(occupancy), 128'd0);
    chk("fl_valid", 128'(m_valid), 128'd0);
    chk("fl_halt", 128'(eng_halt), 128'd0);
    chk("fl_blk", 128'(blk_count), 128'd0);
    chk("fl_ovf", 128'(overflow_err), 128'd1);

    // Normal operation after flush
    eng_out = BLK; eng_out_valid = 1'b1; m_ready = 1'b1;
    q.push_back(BLK);
    tick();
    eng_out_valid = 1'b0;
    chk("post_fl_blk", 128'(blk_count), 128'd1);
    tick();
    chk("post_fl_occ", 128'(occupancy), 128'd0);
    chk("post_fl_sb", 128'(q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
